multicycle_maindec: RTL and testbench

MULTICYCLE_MAINDEC -- requirements
Module: multicycle_maindec

---
 rtl/multicycle_maindec.sv | 176 +++++++++++++++++
 tb/tb_multicycle_maindec.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_maindec.sv
// rtl/multicycle_maindec.sv - multicycle MIPS-style main control FSM
// Moore decode of the state register; only FETCH strobes and DECODE illegal_op look at inputs.
module multicycle_maindec #(
  parameter int unsigned ALUOP_W  = 2,
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned EN_BNE   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               irwrite,
  output logic               memwrite,
  output logic               regwrite,
  output logic               iord,
  output logic               alusrca,
  output logic               regdst,
  output logic               memtoreg,
  output logic               branch,
  output logic               branch_ne,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [ALUOP_W-1:0] aluop,
  output logic               illegal_op,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t     cur;
  state_t     dec_next;
  logic       dec_legal;
  logic [5:0] op_q;
  logic       mem_rdy;
  logic [1:0] aluop_lo;

  assign mem_rdy = (MEM_WAIT != 0) ? mem_ready : 1'b1;
  assign state   = cur;
  assign aluop   = ALUOP_W'(aluop_lo);

  always_comb begin
    dec_next  = FETCH;
    dec_legal = 1'b1;
    case (opcode)
      OP_LW, OP_SW: dec_next = MEMADR;
      OP_RTYP:      dec_next = EXECUTE;
      OP_BEQ:       dec_next = BRANCH;
      OP_BNE: begin
        if (EN_BNE != 0) dec_next = BRANCH;
        else             dec_legal = 1'b0;
      end
      OP_ADDI:      dec_next = ADDIEX;
      OP_J:         dec_next = JUMP;
      default:      dec_legal = 1'b0;
    endcase
  end

  // The opcode is latched on leaving DECODE so later states never see the live bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur  <= FETCH;
      op_q <= 6'b0;
    end else begin
      case (cur)
        FETCH:   if (mem_rdy) cur <= DECODE;
        DECODE: begin
          op_q <= opcode;
          cur  <= dec_next;
        end
        MEMADR:  cur <= (op_q == OP_SW) ? MEMWR : MEMRD;
        MEMRD:   if (mem_rdy) cur <= MEMWB;
        MEMWB:   cur <= FETCH;
        MEMWR:   if (mem_rdy) cur <= FETCH;
        EXECUTE: cur <= ALUWB;
        ALUWB:   cur <= FETCH;
        BRANCH:  cur <= FETCH;
        ADDIEX:  cur <= ADDIWB;
        ADDIWB:  cur <= FETCH;
        JUMP:    cur <= FETCH;
        default: cur <= FETCH;
      endcase
    end
  end

  // Outputs are forced low while reset is held, even though the state reads FETCH.
  always_comb begin
    pcwrite    = 1'b0;
    irwrite    = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    iord       = 1'b0;
    alusrca    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop_lo   = 2'b00;
    illegal_op = 1'b0;
    if (reset) begin
      case (cur)
        FETCH: begin
          alusrcb = 2'b01;
          irwrite = mem_rdy;
          pcwrite = mem_rdy;
        end
        DECODE: begin
          alusrcb    = 2'b11;
          illegal_op = ~dec_legal;
        end
        MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        MEMRD:   iord = 1'b1;
        MEMWB: begin
          memtoreg = 1'b1;
          regwrite = 1'b1;
        end
        MEMWR: begin
          iord     = 1'b1;
          memwrite = 1'b1;
        end
        EXECUTE: begin
          alusrca  = 1'b1;
          aluop_lo = 2'b10;
        end
        ALUWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
        end
        BRANCH: begin
          alusrca   = 1'b1;
          aluop_lo  = 2'b01;
          pcsrc     = 2'b01;
          branch    = (op_q == OP_BEQ);
          branch_ne = (op_q == OP_BNE);
        end
        ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        ADDIWB:  regwrite = 1'b1;
        JUMP: begin
          pcsrc   = 2'b10;
          pcwrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_maindec.sv
// tb/tb_multicycle_maindec.sv - directed bench for multicycle_maindec
// Three instances: defaults, EN_BNE=0, and MEM_WAIT=0 with a 3-bit aluop.
module tb_multicycle_maindec;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       ready_tied;

  logic m_pcwrite, m_irwrite, m_memwrite, m_regwrite, m_iord, m_alusrca, m_regdst, m_memtoreg;
  logic m_branch, m_branch_ne, m_illegal;
  logic [1:0] m_alusrcb, m_pcsrc, m_aluop;
  logic [3:0] m_state;

  logic n_pcwrite, n_irwrite, n_memwrite, n_regwrite, n_iord, n_alusrca, n_regdst, n_memtoreg;
  logic n_branch, n_branch_ne, n_illegal;
  logic [1:0] n_alusrcb, n_pcsrc, n_aluop;
  logic [3:0] n_state;

  logic w_pcwrite, w_irwrite, w_memwrite, w_regwrite, w_iord, w_alusrca, w_regdst, w_memtoreg;
  logic w_branch, w_branch_ne, w_illegal;
  logic [1:0] w_alusrcb, w_pcsrc;
  logic [2:0] w_aluop;
  logic [3:0] w_state;

  logic [16:0] m_vec, n_vec, w_vec;
  assign m_vec = {m_pcwrite, m_irwrite, m_memwrite, m_regwrite, m_iord, m_alusrca, m_regdst, m_memtoreg,
                  m_branch, m_branch_ne, m_illegal, m_alusrcb, m_pcsrc, m_aluop};
  assign n_vec = {n_pcwrite, n_irwrite, n_memwrite, n_regwrite, n_iord, n_alusrca, n_regdst, n_memtoreg,
                  n_branch, n_branch_ne, n_illegal, n_alusrcb, n_pcsrc, n_aluop};
  assign w_vec = {w_pcwrite, w_irwrite, w_memwrite, w_regwrite, w_iord, w_alusrca, w_regdst, w_memtoreg,
                  w_branch, w_branch_ne, w_illegal, w_alusrcb, w_pcsrc, w_aluop[1:0]};

  // {pcw,irw,memw,regw,iord,asrca,regdst,m2r, br,brne,ill, alusrcb, pcsrc, aluop}
  localparam logic [16:0] E_ZERO   = 17'b0;
  localparam logic [16:0] E_FETCH  = {8'b1100_0000, 3'b000, 2'b01, 2'b00, 2'b00};
  localparam logic [16:0] E_FSTALL = {8'b0000_0000, 3'b000, 2'b01, 2'b00, 2'b00};
  localparam logic [16:0] E_DECODE = {8'b0000_0000, 3'b000, 2'b11, 2'b00, 2'b00};
  localparam logic [16:0] E_ILLDEC = {8'b0000_0000, 3'b001, 2'b11, 2'b00, 2'b00};
  localparam logic [16:0] E_MEMADR = {8'b0000_0100, 3'b000, 2'b10, 2'b00, 2'b00};
  localparam logic [16:0] E_MEMRD  = {8'b0000_1000, 3'b000, 2'b00, 2'b00, 2'b00};
  localparam logic [16:0] E_MEMWB  = {8'b0001_0001, 3'b000, 2'b00, 2'b00, 2'b00};
  localparam logic [16:0] E_MEMWR  = {8'b0010_1000, 3'b000, 2'b00, 2'b00, 2'b00};
  localparam logic [16:0] E_EXEC   = {8'b0000_0100, 3'b000, 2'b00, 2'b00, 2'b10};
  localparam logic [16:0] E_ALUWB  = {8'b0001_0010, 3'b000, 2'b00, 2'b00, 2'b00};
  localparam logic [16:0] E_BEQ    = {8'b0000_0100, 3'b100, 2'b00, 2'b01, 2'b01};
  localparam logic [16:0] E_BNE    = {8'b0000_0100, 3'b010, 2'b00, 2'b01, 2'b01};
  localparam logic [16:0] E_ADDIEX = {8'b0000_0100, 3'b000, 2'b10, 2'b00, 2'b00};
  localparam logic [16:0] E_ADDIWB = {8'b0001_0000, 3'b000, 2'b00, 2'b00, 2'b00};
  localparam logic [16:0] E_JUMP   = {8'b1000_0000, 3'b000, 2'b00, 2'b10, 2'b00};

  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101, OP_ADDI = 6'b001000, OP_J = 6'b000010, OP_BAD = 6'b111111;

  int vectors;
  int miscompares;

  multicycle_maindec u_main (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(m_pcwrite), .irwrite(m_irwrite), .memwrite(m_memwrite), .regwrite(m_regwrite),
    .iord(m_iord), .alusrca(m_alusrca), .regdst(m_regdst), .memtoreg(m_memtoreg),
    .branch(m_branch), .branch_ne(m_branch_ne), .alusrcb(m_alusrcb), .pcsrc(m_pcsrc),
    .aluop(m_aluop), .illegal_op(m_illegal), .state(m_state));

  multicycle_maindec #(.EN_BNE(0)) u_nobne (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(n_pcwrite), .irwrite(n_irwrite), .memwrite(n_memwrite), .regwrite(n_regwrite),
    .iord(n_iord), .alusrca(n_alusrca), .regdst(n_regdst), .memtoreg(n_memtoreg),
    .branch(n_branch), .branch_ne(n_branch_ne), .alusrcb(n_alusrcb), .pcsrc(n_pcsrc),
    .aluop(n_aluop), .illegal_op(n_illegal), .state(n_state));

  multicycle_maindec #(.MEM_WAIT(0), .ALUOP_W(3)) u_nowait (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(ready_tied),
    .pcwrite(w_pcwrite), .irwrite(w_irwrite), .memwrite(w_memwrite), .regwrite(w_regwrite),
    .iord(w_iord), .alusrca(w_alusrca), .regdst(w_regdst), .memtoreg(w_memtoreg),
    .branch(w_branch), .branch_ne(w_branch_ne), .alusrcb(w_alusrcb), .pcsrc(w_pcsrc),
    .aluop(w_aluop), .illegal_op(w_illegal), .state(w_state));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mem_ready = 1'b1;
    opcode = 6'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if (m_state !== 4'd0) begin miscompares++; $display("FAIL reset_state got %0d expected 0", m_state); end
    vectors++;
    if (m_vec !== E_ZERO || n_vec !== E_ZERO || w_vec !== E_ZERO) begin
      miscompares++; $display("FAIL reset_outs got %h/%h/%h expected 0", m_vec, n_vec, w_vec);
    end
    step();
    vectors++;
    if (m_vec !== E_ZERO) begin miscompares++; $display("FAIL reset_held_outs got %h expected 0", m_vec); end
    reset = 1'b1;
    #1;
    vectors++;
    if (m_vec !== E_FETCH || m_state !== 4'd0) begin
      miscompares++; $display("FAIL reset_release got %h st %0d expected %h st 0", m_vec, m_state, E_FETCH);
    end
    step();
    vectors++;
    if (m_state !== 4'd1) begin miscompares++; $display("FAIL first_fetch got %0d expected 1", m_state); end
  endtask

  task automatic test_lw();
    logic [3:0]  es [6];
    logic [16:0] ev [6];
    es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    ev = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH};
    do_reset();
    opcode = OP_LW;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) opcode = OP_SW;
      #1;
      vectors++;
      if (m_state !== es[i] || m_vec !== ev[i]) begin
        miscompares++;
        $display("FAIL lw cyc %0d got st %0d out %h expected st %0d out %h", i, m_state, m_vec, es[i], ev[i]);
      end
      step();
    end
  endtask

  task automatic test_sw_stall();
    logic [3:0]  es [8];
    logic [16:0] ev [8];
    logic        rd [8];
    int          wr_cycles;
    es = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
    ev = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR, E_MEMWR, E_MEMWR, E_MEMWR, E_FETCH};
    rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    wr_cycles = 0;
    do_reset();
    opcode = OP_SW;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rd[i];
      #1;
      if (m_memwrite) wr_cycles++;
      vectors++;
      if (m_state !== es[i] || m_vec !== ev[i]) begin
        miscompares++;
        $display("FAIL sw cyc %0d got st %0d out %h expected st %0d out %h", i, m_state, m_vec, es[i], ev[i]);
      end
      step();
    end
    vectors++;
    if (wr_cycles != 4) begin miscompares++; $display("FAIL sw_memwrite_len got %0d expected 4", wr_cycles); end
  endtask

  task automatic test_rtype_addi_jump();
    logic [5:0]  ops [3];
    logic [3:0]  es  [3][5];
    logic [16:0] ev  [3][5];
    ops = '{OP_R, OP_ADDI, OP_J};
    es  = '{'{4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, '{4'd0, 4'd1, 4'd9, 4'd10, 4'd0}, '{4'd0, 4'd1, 4'd11, 4'd0, 4'd1}};
    ev  = '{'{E_FETCH, E_DECODE, E_EXEC, E_ALUWB, E_FETCH},
            '{E_FETCH, E_DECODE, E_ADDIEX, E_ADDIWB, E_FETCH},
            '{E_FETCH, E_DECODE, E_JUMP, E_FETCH, E_DECODE}};
    for (int t = 0; t < 3; t++) begin
      do_reset();
      opcode = ops[t];
      for (int i = 0; i < 5; i++) begin
        #1;
        vectors++;
        if (m_state !== es[t][i] || m_vec !== ev[t][i]) begin
          miscompares++;
          $display("FAIL op%0d cyc %0d got st %0d out %h expected st %0d out %h",
                   t, i, m_state, m_vec, es[t][i], ev[t][i]);
        end
        if (t == 0 && i == 2) begin
          vectors++;
          if (w_aluop !== 3'b010) begin miscompares++; $display("FAIL aluop_wide got %b expected 010", w_aluop); end
        end
        step();
      end
    end
  endtask

  task automatic test_branches();
    logic [3:0]  ns [4];
    logic [16:0] nv [4];
    int          ill;
    ns = '{4'd0, 4'd1, 4'd0, 4'd1};
    nv = '{E_FETCH, E_ILLDEC, E_FETCH, E_DECODE};
    do_reset();
    opcode = OP_BEQ;
    step();
    #1;
    step();
    #1;
    vectors++;
    if (m_state !== 4'd8 || m_vec !== E_BEQ) begin
      miscompares++; $display("FAIL beq got st %0d out %h expected st 8 out %h", m_state, m_vec, E_BEQ);
    end
    step();
    #1;
    vectors++;
    if (m_state !== 4'd0) begin miscompares++; $display("FAIL beq_ret got %0d expected 0", m_state); end
    do_reset();
    opcode = OP_BNE;
    ill = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) opcode = OP_J;
      #1;
      if (n_illegal) ill++;
      if (i == 2) begin
        vectors++;
        if (m_state !== 4'd8 || m_vec !== E_BNE) begin
          miscompares++; $display("FAIL bne got st %0d out %h expected st 8 out %h", m_state, m_vec, E_BNE);
        end
      end
      vectors++;
      if (n_state !== ns[i] || n_vec !== nv[i]) begin
        miscompares++;
        $display("FAIL bne_off cyc %0d got st %0d out %h expected st %0d out %h", i, n_state, n_vec, ns[i], nv[i]);
      end
      step();
    end
    vectors++;
    if (ill != 1) begin miscompares++; $display("FAIL bne_off_pulses got %0d expected 1", ill); end
  endtask

  task automatic test_illegal();
    logic [3:0]  es [4];
    logic [16:0] ev [4];
    int          ill;
    int          wr;
    es = '{4'd0, 4'd1, 4'd0, 4'd1};
    ev = '{E_FETCH, E_ILLDEC, E_FETCH, E_DECODE};
    ill = 0;
    wr = 0;
    do_reset();
    opcode = OP_BAD;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) opcode = OP_J;
      #1;
      if (m_illegal) ill++;
      if (m_memwrite || m_regwrite) wr++;
      vectors++;
      if (m_state !== es[i] || m_vec !== ev[i]) begin
        miscompares++;
        $display("FAIL illegal cyc %0d got st %0d out %h expected st %0d out %h", i, m_state, m_vec, es[i], ev[i]);
      end
      step();
    end
    vectors++;
    if (ill != 1 || wr != 0) begin
      miscompares++; $display("FAIL illegal_pulse got pulses %0d writes %0d expected 1 and 0", ill, wr);
    end
  endtask

  task automatic test_reset_mid_memrd();
    do_reset();
    opcode = OP_LW;
    repeat (3) step();
    mem_ready = 1'b0;
    #1;
    vectors++;
    if (m_state !== 4'd3 || m_vec !== E_MEMRD) begin
      miscompares++; $display("FAIL memrd_stall got st %0d out %h expected st 3 out %h", m_state, m_vec, E_MEMRD);
    end
    step();
    #1;
    mem_ready = 1'b1;
    reset = 1'b0;
    #1;
    vectors++;
    if (m_state !== 4'd0 || m_vec !== E_ZERO) begin
      miscompares++; $display("FAIL mid_reset got st %0d out %h expected st 0 out 0", m_state, m_vec);
    end
    step();
    vectors++;
    if (m_state !== 4'd0 || m_vec !== E_ZERO) begin
      miscompares++; $display("FAIL mid_reset_hold got st %0d out %h expected st 0 out 0", m_state, m_vec);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (m_state !== 4'd0 || m_vec !== E_FETCH) begin
      miscompares++; $display("FAIL mid_reset_fetch got st %0d out %h expected st 0 out %h", m_state, m_vec, E_FETCH);
    end
    step();
    vectors++;
    if (m_state !== 4'd1) begin miscompares++; $display("FAIL mid_reset_decode got %0d expected 1", m_state); end
  endtask

  task automatic test_mem_wait_off();
    logic [3:0]  es [6];
    logic [16:0] ev [6];
    es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    ev = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH};
    do_reset();
    opcode = OP_LW;
    mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      vectors++;
      if (w_state !== es[i] || w_vec !== ev[i] || w_aluop[2] !== 1'b0) begin
        miscompares++;
        $display("FAIL nowait cyc %0d got st %0d out %h expected st %0d out %h", i, w_state, w_vec, es[i], ev[i]);
      end
      vectors++;
      if (m_state !== 4'd0 || m_vec !== E_FSTALL) begin
        miscompares++;
        $display("FAIL fetch_stall cyc %0d got st %0d out %h expected st 0 out %h", i, m_state, m_vec, E_FSTALL);
      end
      step();
    end
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b0;
    opcode = 6'b0;
    mem_ready = 1'b1;
    ready_tied = 1'b0;
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_lw();
    test_sw_stall();
    test_rtype_addi_jump();
    test_branches();
    test_illegal();
    test_reset_mid_memrd();
    test_mem_wait_off();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
